// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-side definitions: reset PC, fetch FSM encoding and the
// branch-control codes agreed with the branch unit.
package pc_fetch_unit_pkg;

    localparam logic [31:0] PKG_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding-to-be at pc
        WAIT  = 2'd1,   // granted, waiting for rvalid
        HOLD  = 2'd2,   // instruction presented to decode
        DROP  = 2'd3    // redirected while a response is still in flight
    } fetch_state_e;

    typedef enum logic [1:0] {
        BR_FLOW = 2'd0,
        BR_BEQ  = 2'd1,
        BR_J    = 2'd2
    } br_ctrl_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   br_branch/br_offset        : taken-branch redirect, new pc = acc_pc + 4 + offset
//   br_jump/br_target          : jump redirect, new pc = target (wins over branch)
//   imem_req/addr/gnt          : single-outstanding request channel to instruction memory
//   imem_rvalid/rdata          : response channel, one beat per grant
//   inst_valid/inst/inst_pc    : instruction to decode, accepted by dec_ready
//   pc_h4                      : top nibble of (last accepted pc + 4)
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = ADDR_W'(PKG_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_branch,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              br_jump,
    input  logic [ADDR_W-1:0] br_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              dec_ready,
    output logic [3:0]        pc_h4
);

    fetch_state_e      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] acc_pc, acc_pc_nxt;
    logic [ADDR_W-1:0] inst_pc_nxt;
    logic [31:0]       inst_nxt;
    logic              inst_valid_nxt;
    logic              redirect;
    logic [ADDR_W-1:0] new_pc;
    logic [ADDR_W-1:0] acc_pc_p4;

    assign redirect  = br_jump || br_branch;
    assign acc_pc_p4 = acc_pc + ADDR_W'(4);
    assign new_pc    = br_jump ? br_target : acc_pc_p4 + br_offset;
    assign pc_h4     = acc_pc_p4[ADDR_W-1 -: 4];

    assign imem_req  = (state == FETCH) && !reset;
    assign imem_addr = pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        acc_pc_nxt     = acc_pc;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        inst_valid_nxt = inst_valid;

        case (state)
            FETCH: begin
                // A redirect in the grant cycle leaves a response in flight
                // that belongs to the old path.
                if (imem_gnt)
                    state_nxt = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    state_nxt = imem_rvalid ? FETCH : DROP;
                end else if (imem_rvalid) begin
                    state_nxt      = HOLD;
                    inst_nxt       = imem_rdata;
                    inst_pc_nxt    = pc;
                    pc_nxt         = pc + ADDR_W'(4);
                    inst_valid_nxt = 1'b1;
                end
            end
            HOLD: begin
                // Redirect cancels a same-cycle accept: acc_pc is not advanced.
                if (redirect) begin
                    state_nxt      = FETCH;
                    inst_valid_nxt = 1'b0;
                end else if (dec_ready) begin
                    state_nxt      = FETCH;
                    acc_pc_nxt     = inst_pc;
                    inst_valid_nxt = 1'b0;
                end
            end
            DROP: begin
                if (imem_rvalid)
                    state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        if (redirect)
            pc_nxt = new_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            acc_pc     <= RESET_PC - ADDR_W'(4);
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            acc_pc     <= acc_pc_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            inst_valid <= inst_valid_nxt;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_branch;
    logic [31:0] br_offset;
    logic        br_jump;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        dec_ready;
    logic [3:0]  pc_h4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .reset       (reset),
        .br_branch   (br_branch),
        .br_offset   (br_offset),
        .br_jump     (br_jump),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .dec_ready   (dec_ready),
        .pc_h4       (pc_h4)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-wait fetch of one instruction starting in FETCH, accepted immediately.
    task automatic fetch_one(input logic [31:0] a, input logic [31:0] w);
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, a);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        chk("wait_req", {31'b0, imem_req}, 32'd0);
        chk("wait_valid", {31'b0, inst_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        cyc();
        imem_rvalid = 1'b0;
        chk("hold_valid", {31'b0, inst_valid}, 32'd1);
        chk("hold_inst", inst, w);
        chk("hold_pc", inst_pc, a);
        chk("hold_req", {31'b0, imem_req}, 32'd0);
        dec_ready = 1'b1;
        cyc();
        dec_ready = 1'b0;
        chk("acc_valid", {31'b0, inst_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; br_branch = 1'b0; br_offset = '0; br_jump = 1'b0; br_target = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
        cyc();
        cyc();
        // Reset state
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_h4", {28'b0, pc_h4}, 32'h0);
        reset = 1'b0;
        #1;

        // 1: sequential fetch
        fetch_one(32'h0000_3000, 32'h1111_3000);
        fetch_one(32'h0000_3004, 32'h1111_3004);
        fetch_one(32'h0000_3008, 32'h1111_3008);

        // 2: branch after accepting 300C; response for 3010 must be dropped
        fetch_one(32'h0000_300C, 32'h1111_300C);
        chk("t2_addr3010", imem_addr, 32'h0000_3010);
        br_branch = 1'b1; br_offset = 32'h10; imem_gnt = 1'b1;
        cyc();
        br_branch = 1'b0; br_offset = '0; imem_gnt = 1'b0;
        chk("t2_drop_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_3010;
        cyc();
        imem_rvalid = 1'b0;
        chk("t2_no_inst", {31'b0, inst_valid}, 32'd0);
        fetch_one(32'h0000_3020, 32'h2222_3020);

        // 3: jump while WAIT, stale response three cycles later
        chk("t3_addr", imem_addr, 32'h0000_3024);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        br_jump = 1'b1; br_target = 32'h0040_0000;
        cyc();
        br_jump = 1'b0; br_target = '0;
        cyc();
        cyc();
        chk("t3_drop_req", {31'b0, imem_req}, 32'd0);
        chk("t3_drop_valid", {31'b0, inst_valid}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_3024;
        cyc();
        imem_rvalid = 1'b0;
        chk("t3_valid", {31'b0, inst_valid}, 32'd0);
        fetch_one(32'h0040_0000, 32'h3333_0000);

        // 4: decode stall in HOLD
        chk("t4_addr", imem_addr, 32'h0040_0004);
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h4444_0004;
        cyc();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_valid", {31'b0, inst_valid}, 32'd1);
            chk("t4_stall_inst", inst, 32'h4444_0004);
            chk("t4_stall_pc", inst_pc, 32'h0040_0004);
            chk("t4_stall_req", {31'b0, imem_req}, 32'd0);
            cyc();
        end
        dec_ready = 1'b1;
        cyc();
        dec_ready = 1'b0;
        chk("t4_released", {31'b0, inst_valid}, 32'd0);
        chk("t4_next_addr", imem_addr, 32'h0040_0008);

        // 5: jump and branch together, request not granted
        chk("t5_req", {31'b0, imem_req}, 32'd1);
        br_jump = 1'b1; br_branch = 1'b1; br_target = 32'h0000_1000; br_offset = 32'h100;
        cyc();
        br_jump = 1'b0; br_branch = 1'b0; br_target = '0; br_offset = '0;
        fetch_one(32'h0000_1000, 32'h5555_1000);
        chk("t5_h4", {28'b0, pc_h4}, 32'h0);

        // pc_h4 upper nibble and pc wrap
        br_jump = 1'b1; br_target = 32'hEFFF_FFFC;
        cyc();
        br_jump = 1'b0;
        fetch_one(32'hEFFF_FFFC, 32'h6666_FFFC);
        chk("h4_F", {28'b0, pc_h4}, 32'hF);
        chk("addr_F0", imem_addr, 32'hF000_0000);
        br_jump = 1'b1; br_target = 32'hFFFF_FFFC;
        cyc();
        br_jump = 1'b0;
        fetch_one(32'hFFFF_FFFC, 32'h7777_FFFC);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_h4", {28'b0, pc_h4}, 32'h0);

        // Redirect in HOLD cancels a same-cycle accept
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'h8888_0000;
        cyc();
        imem_rvalid = 1'b0;
        chk("hr_valid", {31'b0, inst_valid}, 32'd1);
        dec_ready = 1'b1; br_branch = 1'b1; br_offset = 32'h20;
        cyc();
        dec_ready = 1'b0; br_branch = 1'b0; br_offset = '0;
        chk("hr_cancel", {31'b0, inst_valid}, 32'd0);
        chk("hr_addr", imem_addr, 32'h0000_0020);
        // acc_pc still FFFF_FFFC, so a zero-offset branch targets 0
        br_branch = 1'b1; br_offset = 32'h0;
        cyc();
        br_branch = 1'b0;
        chk("hr_acc_kept", imem_addr, 32'h0000_0000);

        // 6: reset during WAIT, stale rvalid afterwards ignored
        imem_gnt = 1'b1;
        cyc();
        imem_gnt = 1'b0;
        reset = 1'b1;
        cyc();
        chk("t6_rst_req", {31'b0, imem_req}, 32'd0);
        reset = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0000;
        #1;
        chk("t6_addr", imem_addr, 32'h0000_3000);
        chk("t6_h4", {28'b0, pc_h4}, 32'h0);
        cyc();
        imem_rvalid = 1'b0;
        chk("t6_valid", {31'b0, inst_valid}, 32'd0);
        chk("t6_inst", inst, 32'd0);
        fetch_one(32'h0000_3000, 32'h9999_3000);
        chk("t6_next", imem_addr, 32'h0000_3004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
